// File: rtl/divider_pkg.sv
// Shared types and defaults for the iterative divider slice.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  next_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    logic [DATA_WIDTH:0] shifted;

    // The true difference is below the divisor, so modulo-2^W subtraction is exact.
    always_comb begin
        shifted = {rem_in, next_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? (shifted[DATA_WIDTH-1:0] - divisor) : shifted[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/divider_iter.sv
// Iterative unsigned 2W/W restoring divider, one quotient bit per enabled clock.
// Define DIVIDER_ITER_EARLY_ERR_EN to skip the iterations for error cases.
module divider_iter
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0]   divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]   remainder,
    output logic                    err
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] div_q, div_d;
    logic                  err_flag_q, err_flag_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] step_rem;
    logic                  step_bit;
    logic                  in_err;

    div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .next_bit(quo_q[DATA_WIDTH-1]),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    assign in_err = (divisor == '0) || (dividend[2*DATA_WIDTH-1:DATA_WIDTH] >= divisor);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        err_flag_d  = err_flag_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d      = divisor;
                    rem_d      = dividend[2*DATA_WIDTH-1:DATA_WIDTH];
                    quo_d      = dividend[DATA_WIDTH-1:0];
                    cnt_d      = '0;
                    err_flag_d = in_err;
                    state_d    = BUSY;
`ifdef DIVIDER_ITER_EARLY_ERR_EN
                    if (in_err) state_d = DONE;
`endif
                end
            end
            BUSY: begin
                rem_d = step_rem;
                quo_d = {quo_q[DATA_WIDTH-2:0], step_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) state_d = DONE;
            end
            DONE: begin
                // First DONE cycle commits the result; out_valid rises one edge later.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    quotient_d  = err_flag_q ? '1 : quo_q;
                    remainder_d = err_flag_q ? '0 : rem_q;
                    err_d       = err_flag_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            err_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            err_q       <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            err_flag_q  <= err_flag_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign err       = err_q;

endmodule

// File: tb/tb_divider_iter.sv
// Directed, table-driven bench for divider_iter at DATA_WIDTH=8.
module tb_divider_iter;

    localparam int W = 8;
    localparam int NORM_EDGES = W + 2;
`ifdef DIVIDER_ITER_EARLY_ERR_EN
    localparam int ERR_EDGES = 2;
`else
    localparam int ERR_EDGES = W + 2;
`endif

    logic           clk = 1'b0;
    logic           rstn, en, in_valid, in_ready, out_valid, out_ready, err;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor, quotient, remainder;

    int checks = 0;
    int errors = 0;

    divider_iter #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           e;
        int             edges;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns #1 after the accept edge with inputs scrambled.
    task automatic accept_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        dividend  = dvd;
        divisor   = dvs;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check("in_ready_before_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'hFFFF;
        divisor  = 8'h01;
    endtask

    task automatic wait_valid(input int start, output int edges);
        edges = start;
        while (out_valid !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_release", int'(in_ready), 1);
        check("out_valid_after_release", int'(out_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ed;
        vecs[0] = '{16'd1000,  8'd7,    8'd142,  8'd6,   1'b0, NORM_EDGES};
        vecs[1] = '{16'd55,    8'd0,    8'hFF,   8'd0,   1'b1, ERR_EDGES};
        vecs[2] = '{16'h0100,  8'd1,    8'hFF,   8'd0,   1'b1, ERR_EDGES};
        vecs[3] = '{16'h00FF,  8'd1,    8'd255,  8'd0,   1'b0, NORM_EDGES};
        vecs[4] = '{16'd200,   8'd3,    8'd66,   8'd2,   1'b0, NORM_EDGES};
        vecs[5] = '{16'hFFFF,  8'hFF,   8'hFF,   8'd0,   1'b1, ERR_EDGES};
        vecs[6] = '{16'hFEFF,  8'hFF,   8'd255,  8'd254, 1'b0, NORM_EDGES};
        vecs[7] = '{16'd0,     8'd5,    8'd0,    8'd0,   1'b0, NORM_EDGES};
        vecs[8] = '{16'h1234,  8'h80,   8'd36,   8'd52,  1'b0, NORM_EDGES};
        vecs[9] = '{16'd12345, 8'd100,  8'd123,  8'd45,  1'b0, NORM_EDGES};

        rstn = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            accept_op(vecs[i].dvd, vecs[i].dvs);
            wait_valid(1, ed);
            check($sformatf("v%0d_latency", i), ed, vecs[i].edges);
            check($sformatf("v%0d_quotient", i), int'(quotient), int'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), int'(remainder), int'(vecs[i].r));
            check($sformatf("v%0d_err", i), int'(err), int'(vecs[i].e));
            release_out();
        end

        // Backpressure: hold out_ready low for 5 cycles after out_valid.
        @(negedge clk);
        accept_op(16'd1000, 8'd7);
        wait_valid(1, ed);
        check("bp_latency", ed, NORM_EDGES);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_quotient", int'(quotient), 142);
            check("bp_remainder", int'(remainder), 6);
            check("bp_err", int'(err), 0);
        end
        release_out();

        // Clock enable low for 3 cycles mid-BUSY.
        @(negedge clk);
        accept_op(16'd1000, 8'd7);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", int'(out_valid), 0);
            check("stall_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        en = 1'b1;
        wait_valid(7, ed);
        check("stall_latency", ed, NORM_EDGES + 3);
        check("stall_quotient", int'(quotient), 142);
        check("stall_remainder", int'(remainder), 6);
        check("stall_err", int'(err), 0);
        release_out();

        // Reset pulse partway through an operation.
        @(negedge clk);
        accept_op(16'd1000, 8'd7);
        repeat (4) begin @(posedge clk); #1; end
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_quotient", int'(quotient), 0);
        check("midrst_remainder", int'(remainder), 0);
        @(negedge clk);
        rstn = 1'b1;
        accept_op(16'd200, 8'd3);
        wait_valid(1, ed);
        check("postrst_latency", ed, NORM_EDGES);
        check("postrst_quotient", int'(quotient), 66);
        check("postrst_remainder", int'(remainder), 2);
        check("postrst_err", int'(err), 0);
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
